fetch_buffer: RTL
=================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter Width, default 16, giving the instruction word and IN port data width.
REQ-002 SHALL have parameter PcWidth, default 32, giving the program counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the falling edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port instr_in  input  Width  word from instruction memory this cycle.
REQ-006 SHALL have port pc_in  input  PcWidth  address of instr_in.
REQ-007 SHALL have port in_port_in  input  Width  IN port register value, stable before falling edge.
REQ-008 SHALL have port stall  input  1  hold all state when high.
REQ-009 SHALL have port flush  input  1  discard contents and insert a bubble.
REQ-010 SHALL have port instr_out  output  Width  instruction word to decode.
REQ-011 SHALL have port imm_out  output  Width  immediate word; 0 for one-word instructions.
REQ-012 SHALL have port pc_out  output  PcWidth  PC of the first word of instr_out.
REQ-013 SHALL have port in_port_out  output  Width  IN port value captured with the instruction.
REQ-014 SHALL have port valid_out  output  1  high when the outputs hold a real instruction.
REQ-015 SHALL have port imm_pending  output  1  high while in WAIT_IMM (combinational from state).

Function
REQ-016 SHALL register all outputs except imm_pending, updating on the falling edge of clk.
REQ-017 SHALL use a two-state FSM: FIRST (expect opcode word), WAIT_IMM (expect immediate word).
REQ-018 SHALL treat instr_in as two-word when instr_in[0]=1 and the state is FIRST.
REQ-019 SHALL, in FIRST with a one-word instruction: load instr_out=instr_in, imm_out=0, pc_out=pc_in, in_port_out=in_port_in, valid_out=1; stay in FIRST.
REQ-020 SHALL, in FIRST with a two-word instruction: latch instr_in and pc_in into internal hold registers, drive a bubble (instr_out=0, imm_out=0, valid_out=0), and go to WAIT_IMM.
REQ-021 SHALL, in WAIT_IMM: load instr_out=held word, pc_out=held PC, imm_out=instr_in, in_port_out=in_port_in, valid_out=1; go to FIRST.
REQ-022 SHALL NOT decode instr_in[0] in WAIT_IMM; the immediate word is taken verbatim.
REQ-023 SHALL, when stall=1 and flush=0, hold all outputs, hold registers and FSM state unchanged.
REQ-024 SHALL, when flush=1, regardless of stall: load instr_out=0, imm_out=0, pc_out=0, in_port_out=0, valid_out=0, clear the hold registers, and go to FIRST, discarding any pending first word.
REQ-025 SHALL apply this priority: rst > flush > stall > normal operation.
REQ-026 SHALL give a latency of one falling edge for one-word instructions, and one falling edge after the immediate word for two-word instructions.
REQ-027 SHALL compute no arithmetic on PC; pc_out is passed through at exactly PcWidth bits.

Reset
REQ-028 SHALL, while rst=1, immediately force instr_out=0, imm_out=0, pc_out=0, in_port_out=0, valid_out=0, hold registers to 0, and FSM to FIRST (so imm_pending=0).
REQ-029 SHALL, when rst asserts mid-operation in WAIT_IMM, discard the held word; the first edge after release starts in FIRST.

Verification
REQ-030 SHALL verify: one-word: instr_in=16'h1200, pc_in=5, in_port_in=16'hABCD, then a falling edge -> instr_out=16'h1200, pc_out=5, in_port_out=16'hABCD, imm_out=0, valid_out=1.
REQ-031 SHALL verify: two-word: instr_in=16'h3401, pc_in=8 at edge 1, then instr_in=16'h00FF, in_port_in=16'h0007 at edge 2 -> after edge 1 valid_out=0, imm_pending=1; after edge 2 instr_out=16'h3401, imm_out=16'h00FF, pc_out=8, in_port_out=16'h0007, valid_out=1, imm_pending=0.
REQ-032 SHALL verify: stall=1 for 3 edges with changing instr_in -> all outputs and imm_pending are unchanged.
REQ-033 SHALL verify: flush=1 with stall=1 while in WAIT_IMM -> next edge gives all outputs 0, valid_out=0, imm_pending=0; the next word is decoded as an opcode.
REQ-034 SHALL verify: rst pulsed between edges while in WAIT_IMM -> outputs 0 and imm_pending=0 with no clock edge required.
REQ-035 SHALL verify: instr_in=16'h0001 as the immediate word -> accepted as immediate, not as a new two-word opcode.

Source files
------------

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch buffer joining two-word instructions with their immediate.
// Registers the decode-facing outputs on the falling edge of clk.
module fetch_buffer #(
  parameter int Width   = 16,
  parameter int PcWidth = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [Width-1:0]   instr_in,
  input  logic [PcWidth-1:0] pc_in,
  input  logic [Width-1:0]   in_port_in,
  input  logic               stall,
  input  logic               flush,
  output logic [Width-1:0]   instr_out,
  output logic [Width-1:0]   imm_out,
  output logic [PcWidth-1:0] pc_out,
  output logic [Width-1:0]   in_port_out,
  output logic               valid_out,
  output logic               imm_pending
);

  typedef enum logic {FIRST, WAIT_IMM} state_t;

  state_t               state_q, state_d;
  logic [Width-1:0]     hold_instr_q, hold_instr_d;
  logic [PcWidth-1:0]   hold_pc_q, hold_pc_d;
  logic [Width-1:0]     instr_d, imm_d, in_port_d;
  logic [PcWidth-1:0]   pc_d;
  logic                 valid_d;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FIRST;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      instr_out    <= '0;
      imm_out      <= '0;
      pc_out       <= '0;
      in_port_out  <= '0;
      valid_out    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      instr_out    <= instr_d;
      imm_out      <= imm_d;
      pc_out       <= pc_d;
      in_port_out  <= in_port_d;
      valid_out    <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    instr_d      = instr_out;
    imm_d        = imm_out;
    pc_d         = pc_out;
    in_port_d    = in_port_out;
    valid_d      = valid_out;
    if (flush) begin
      state_d      = FIRST;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      instr_d      = '0;
      imm_d        = '0;
      pc_d         = '0;
      in_port_d    = '0;
      valid_d      = 1'b0;
    end else if (!stall) begin
      case (state_q)
        FIRST: begin
          if (instr_in[0]) begin
            // Opcode of a two-word instruction: park it and emit a bubble.
            hold_instr_d = instr_in;
            hold_pc_d    = pc_in;
            instr_d      = '0;
            imm_d        = '0;
            valid_d      = 1'b0;
            state_d      = WAIT_IMM;
          end else begin
            instr_d   = instr_in;
            imm_d     = '0;
            pc_d      = pc_in;
            in_port_d = in_port_in;
            valid_d   = 1'b1;
          end
        end
        WAIT_IMM: begin
          // The immediate is taken verbatim; bit 0 is not an opcode flag here.
          instr_d   = hold_instr_q;
          pc_d      = hold_pc_q;
          imm_d     = instr_in;
          in_port_d = in_port_in;
          valid_d   = 1'b1;
          state_d   = FIRST;
        end
        default: state_d = FIRST;
      endcase
    end
  end

  assign imm_pending = (state_q == WAIT_IMM);

endmodule
